// File: rtl/ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// ctrl_arbiter -- merges debounced buttons, UART keys and gravity ticks into a
// small command FIFO feeding the game core.   Revision: 1.0
// ============================================================================
module ctrl_arbiter #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GRAVITY_CYCLES  = 25000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk_50MHz,
    input  logic       reset_n,
    input  logic [3:0] usr_btn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       game_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       paused,
    output logic [7:0] overflow_cnt
);
    localparam int c_dbw = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_gvw = $clog2(GRAVITY_CYCLES + 1);
    localparam int c_aw  = $clog2(FIFO_DEPTH);
    localparam int c_cw  = c_aw + 1;

    localparam logic [2:0] c_none   = 3'd0;
    localparam logic [2:0] c_left   = 3'd1;
    localparam logic [2:0] c_right  = 3'd2;
    localparam logic [2:0] c_rotate = 3'd3;
    localparam logic [2:0] c_down   = 3'd4;
    localparam logic [2:0] c_drop   = 3'd5;
    localparam logic [2:0] c_hold   = 3'd6;
    localparam logic [2:0] c_pause  = 3'd7;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       deb_lvl;
    logic [3:0]       deb_prev_q;
    logic [3:0]       rise;
    logic             btn_req_vld_q, btn_req_vld_d;
    logic [2:0]       btn_req_cmd_q, btn_req_cmd_d;
    logic             skid_vld_q, skid_vld_d;
    logic [2:0]       skid_cmd_q, skid_cmd_d;
    logic             grav_pend_q, grav_pend_d;
    logic [c_gvw-1:0] grav_cnt_q, grav_cnt_d;
    logic             grav_wrap;
    logic             paused_q, paused_d;
    logic [7:0]       overflow_q, overflow_d;
    logic [8:0]       ovf_sum;
    logic [2:0]       mem_q [FIFO_DEPTH];
    logic [2:0]       mem_d [FIFO_DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]  count_q, count_d;
    logic [2:0]       head;
    logic [2:0]       uart_cmd;
    logic             uart_new;
    logic             uart_src_vld;
    logic [2:0]       uart_src_cmd;
    logic             uart_pushed;
    logic             btn_live;
    logic             btn_drop, uart_drop;
    logic             push, pop, full, can_push;
    logic [2:0]       push_cmd;

    // Per-button debounce: the level flips on the Nth consecutive differing sample.
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
        logic [c_dbw-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (sync2_q[gi] != lvl_q) begin
                if (cnt_q == c_dbw'(DEBOUNCE_CYCLES - 1)) lvl_d = sync2_q[gi];
                else                                      cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_50MHz) begin
            if (!reset_n) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign deb_lvl[gi] = lvl_q;
    end

    assign rise = deb_lvl & ~deb_prev_q;

    always_comb begin
        btn_req_vld_d = |rise;
        btn_req_cmd_d = c_none;
        if      (rise[0]) btn_req_cmd_d = c_right;
        else if (rise[1]) btn_req_cmd_d = c_left;
        else if (rise[2]) btn_req_cmd_d = c_rotate;
        else if (rise[3]) btn_req_cmd_d = c_down;
    end

    always_comb begin
        uart_cmd = c_none;
        if (rx_valid) begin
            case (rx_data)
                8'h61:   uart_cmd = c_left;
                8'h64:   uart_cmd = c_right;
                8'h77:   uart_cmd = c_rotate;
                8'h73:   uart_cmd = c_down;
                8'h20:   uart_cmd = c_drop;
                8'h63:   uart_cmd = c_hold;
                8'h70:   uart_cmd = c_pause;
                default: uart_cmd = c_none;
            endcase
        end
    end

    // Only PAUSE gets through the UART path while paused.
    assign uart_new     = (uart_cmd != c_none) && (!paused_q || uart_cmd == c_pause);
    assign uart_src_vld = skid_vld_q || uart_new;
    assign uart_src_cmd = skid_vld_q ? skid_cmd_q : uart_cmd;
    assign btn_live     = btn_req_vld_q && !paused_q;

    assign cmd_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign cmd       = cmd_valid ? head : c_none;
    assign pop       = cmd_valid && game_ready;
    assign full      = (count_q == c_cw'(FIFO_DEPTH));
    assign can_push  = !full || pop;

    assign grav_wrap = !paused_q && (grav_cnt_q == c_gvw'(GRAVITY_CYCLES - 1));

    always_comb begin
        grav_cnt_d = grav_cnt_q;
        if (!paused_q) grav_cnt_d = grav_wrap ? '0 : grav_cnt_q + 1'b1;
    end

    // Single push port: button, then UART (skid first), then gravity.
    always_comb begin
        push        = 1'b0;
        push_cmd    = c_none;
        uart_pushed = 1'b0;
        btn_drop    = 1'b0;
        uart_drop   = 1'b0;
        skid_vld_d  = skid_vld_q;
        skid_cmd_d  = skid_cmd_q;
        grav_pend_d = grav_pend_q | grav_wrap;

        if (btn_live) begin
            if (can_push) begin
                push     = 1'b1;
                push_cmd = btn_req_cmd_q;
            end else begin
                btn_drop = 1'b1;
            end
        end else if (uart_src_vld && can_push) begin
            push        = 1'b1;
            push_cmd    = uart_src_cmd;
            uart_pushed = 1'b1;
            skid_vld_d  = 1'b0;
        end else if (grav_pend_q && can_push) begin
            push        = 1'b1;
            push_cmd    = c_down;
            grav_pend_d = 1'b0;
        end

        if (uart_new) begin
            if (skid_vld_q) begin
                uart_drop = 1'b1;
            end else if (!uart_pushed) begin
                skid_vld_d = 1'b1;
                skid_cmd_d = uart_cmd;
            end
        end
    end

    assign ovf_sum    = {1'b0, overflow_q} + {8'd0, btn_drop} + {8'd0, uart_drop};
    assign overflow_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    assign paused_d   = paused_q ^ (pop && head == c_pause);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_cmd;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + c_cw'(push) - c_cw'(pop);
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_prev_q    <= '0;
            btn_req_vld_q <= 1'b0;
            btn_req_cmd_q <= c_none;
            skid_vld_q    <= 1'b0;
            skid_cmd_q    <= c_none;
            grav_pend_q   <= 1'b0;
            grav_cnt_q    <= '0;
            paused_q      <= 1'b0;
            overflow_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= c_none;
        end else begin
            sync1_q       <= usr_btn;
            sync2_q       <= sync1_q;
            deb_prev_q    <= deb_lvl;
            btn_req_vld_q <= btn_req_vld_d;
            btn_req_cmd_q <= btn_req_cmd_d;
            skid_vld_q    <= skid_vld_d;
            skid_cmd_q    <= skid_cmd_d;
            grav_pend_q   <= grav_pend_d;
            grav_cnt_q    <= grav_cnt_d;
            paused_q      <= paused_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

    assign paused       = paused_q;
    assign overflow_cnt = overflow_q;

endmodule
`default_nettype wire
